// File: rtl/op_sched_pkg.sv
// Shared types for the operator Tx scheduler: CSR opcodes, mux owners,
// FSM states and the pending-target encoding, plus small decode helpers.
package op_sched_pkg;

    typedef enum logic [2:0] {
        OP_SCAN = 3'd0,
        OP_JOIN = 3'd1,
        OP_DONE = 3'd5
    } t_op_code;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_SCAN = 2'b01,
        OWN_JOIN = 2'b10
    } t_tx_owner;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN,
        ST_DONE
    } t_sched_state;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_SCAN,
        PEND_JOIN,
        PEND_DONE
    } t_pending;

    localparam int QUIET_CYCLES_DEFAULT = 4;
    localparam int QUIET_W              = 4;

    function automatic logic op_is_legal(logic [2:0] code);
        logic legal;
        case (t_op_code'(code))
            OP_SCAN, OP_JOIN, OP_DONE: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic t_pending op_to_pending(logic [2:0] code);
        t_pending p;
        case (t_op_code'(code))
            OP_SCAN: p = PEND_SCAN;
            OP_JOIN: p = PEND_JOIN;
            OP_DONE: p = PEND_DONE;
            default: p = PEND_NONE;
        endcase
        return p;
    endfunction

    function automatic t_tx_owner pend_to_owner(t_pending p);
        t_tx_owner o;
        case (p)
            PEND_SCAN: o = OWN_SCAN;
            PEND_JOIN: o = OWN_JOIN;
            default:   o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/operator_tx_scheduler_drain_timer.sv
// Quiet-cycle counter: counts consecutive cycles with no MPF traffic and
// pulses 'quiet' on the last required quiet cycle of a drain.
module drain_timer
    import op_sched_pkg::*;
#(
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    output logic quiet
);

    localparam logic [QUIET_W-1:0] LAST = QUIET_W'(QUIET_CYCLES - 1);

    logic [QUIET_W-1:0] cnt;

    // 'start' is held high outside a drain, so the count is zero on the first drain cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            cnt <= '0;
        end else if (start || busy) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + QUIET_W'(1);
        end
    end

    assign quiet = !start && !busy && (cnt == LAST);

endmodule

// File: rtl/operator_tx_scheduler.sv
// Hands the shared CCI-P Tx channels between the scan and join units, gating
// Tx and draining MPF traffic on every change of operator.
module operator_tx_scheduler
    import op_sched_pkg::*;
#(
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_wr_en,
    input  logic [2:0]       op_wr_data,
    input  logic             c0NotEmpty,
    input  logic             c1NotEmpty,
    input  logic             scan_done,
    input  logic             join_done,
    output logic [1:0]       tx_owner,
    output logic             tx_enable,
    output logic             scan_active,
    output logic             join_active,
    output logic             query_done,
    output logic             switch_busy,
    output logic [CNT_W-1:0] switch_count,
    output logic             err_illegal
);

    t_sched_state state, next_state;
    t_pending     pending, next_pending, wr_target, drain_target;
    t_tx_owner    owner, next_owner;

    logic wr_legal, wr_illegal, owner_match, owner_done, quiet, entering_active;
    logic next_tx_enable, next_scan_active, next_join_active;

    assign wr_legal     = op_wr_en && op_is_legal(op_wr_data);
    assign wr_illegal   = op_wr_en && !op_is_legal(op_wr_data);
    assign wr_target    = op_to_pending(op_wr_data);
    assign owner_match  = (pend_to_owner(wr_target) == owner) && (owner != OWN_NONE);
    assign owner_done   = (owner == OWN_SCAN && scan_done) || (owner == OWN_JOIN && join_done);
    // A write landing on the final quiet cycle still decides where the drain ends.
    assign drain_target = wr_legal ? wr_target : pending;

    drain_timer #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_drain_timer (
        .clk  (clk),
        .reset(reset),
        .start(state != ST_DRAIN),
        .busy (c0NotEmpty || c1NotEmpty),
        .quiet(quiet)
    );

    // Reset abandons any drain at once; the integrator must hold fiu in reset alongside.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            pending      <= PEND_NONE;
            owner        <= OWN_NONE;
            tx_enable    <= 1'b0;
            scan_active  <= 1'b0;
            join_active  <= 1'b0;
            query_done   <= 1'b0;
            switch_busy  <= 1'b0;
            switch_count <= '0;
            err_illegal  <= 1'b0;
        end else begin
            state       <= next_state;
            pending     <= next_pending;
            owner       <= next_owner;
            tx_enable   <= next_tx_enable;
            scan_active <= next_scan_active;
            join_active <= next_join_active;
            query_done  <= (next_state == ST_DONE);
            switch_busy <= (next_state == ST_DRAIN);
            if (entering_active) begin
                switch_count <= switch_count + CNT_W'(1);
            end
            if (wr_illegal) begin
                err_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        next_state   = state;
        next_pending = pending;
        unique case (state)
            ST_IDLE: begin
                if (wr_legal) begin
                    next_pending = wr_target;
                    next_state   = ST_DRAIN;
                end
            end
            ST_ACTIVE: begin
                if (wr_legal && !owner_match) begin
                    next_pending = wr_target;
                    next_state   = ST_DRAIN;
                end else if (owner_done) begin
                    next_pending = PEND_NONE;
                    next_state   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                next_pending = drain_target;
                if (quiet) begin
                    next_pending = PEND_NONE;
                    case (drain_target)
                        PEND_SCAN, PEND_JOIN: next_state = ST_ACTIVE;
                        PEND_DONE:            next_state = ST_DONE;
                        default:              next_state = ST_IDLE;
                    endcase
                end
            end
            ST_DONE: begin
                if (wr_legal && wr_target != PEND_DONE) begin
                    next_pending = wr_target;
                    next_state   = ST_DRAIN;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        next_owner = OWN_NONE;
        unique case (next_state)
            ST_ACTIVE: next_owner = (state == ST_DRAIN) ? pend_to_owner(drain_target) : owner;
            ST_DRAIN:  next_owner = owner;
            default:   next_owner = OWN_NONE;
        endcase
        entering_active  = (state != ST_ACTIVE) && (next_state == ST_ACTIVE);
        next_tx_enable   = (next_state == ST_ACTIVE);
        next_scan_active = next_tx_enable && (next_owner == OWN_SCAN);
        next_join_active = next_tx_enable && (next_owner == OWN_JOIN);
    end

    assign tx_owner = owner;

endmodule
